sram_rr_arbiter: RTL and testbench

//  Shares one 8x8 single-port SRAM (sync write, async read, tri-stated read bus) between two requester ports, A and B.

---
 rtl/sram_rr_arbiter_pkg.sv | 8 +
 rtl/sram_rr_arbiter_if.sv | 20 ++
 rtl/sram_rr_arbiter_rr_arb2.sv | 10 +
 rtl/sram_rr_arbiter.sv | 81 ++++++++
 tb/tb_sram_rr_arbiter.sv | 123 ++++++++++++
 5 files changed

// File: rtl/sram_rr_arbiter_pkg.sv
// sram_arb_pkg: shared states, port ids and default widths for the SRAM arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} arb_state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if: requester A/B handshakes plus SRAM pins; slave = arbiter side, master = client/SRAM side
interface sram_rr_arbiter_if #(parameter int ADDR_W = 3, parameter int DATA_W = 8);
  logic a_req, a_we, a_ack;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic b_req, b_we, b_ack;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic mem_wri, mem_rd, busy;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_din, mem_dout;
  modport slave (
    input a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dout,
    output a_ack, a_rdata, b_ack, b_rdata, mem_wri, mem_rd, mem_add, mem_din, busy
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dout,
    input a_ack, a_rdata, b_ack, b_rdata, mem_wri, mem_rd, mem_add, mem_din, busy
  );
endinterface

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker (req[0]=A, req[1]=B; tie goes to the port that did not win last)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id = &req ? ~last_gnt : req[1];
endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: shares one single-port SRAM between ports A/B via round-robin IDLE/ACCESS/RESP sequencer (clok, rst, bus slave)
module sram_rr_arbiter import sram_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clok,
  input logic rst,
  sram_rr_arbiter_if.slave bus
);
  arb_state_t state, state_n;
  logic win, win_n, last_gnt, last_n, gnt_valid, gnt_id;
  logic wri_n, rd_n, a_ack_n, b_ack_n, busy_n;
  logic [ADDR_W-1:0] add_n;
  logic [DATA_W-1:0] din_n, a_rdata_n, b_rdata_n;
  rr_arb2 u_arb (.req({bus.b_req, bus.a_req}), .last_gnt(last_gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id));
  always_comb begin
    state_n = state;
    win_n = win;
    last_n = last_gnt;
    wri_n = 1'b0;
    rd_n = 1'b0;
    add_n = bus.mem_add;
    din_n = bus.mem_din;
    a_ack_n = 1'b0;
    b_ack_n = 1'b0;
    a_rdata_n = bus.a_rdata;
    b_rdata_n = bus.b_rdata;
    case (state)
      ST_IDLE: if (gnt_valid) begin
        state_n = ST_ACCESS;
        win_n = gnt_id;
        wri_n = gnt_id ? bus.b_we : bus.a_we;
        rd_n = ~wri_n;
        add_n = gnt_id ? bus.b_addr : bus.a_addr;
        din_n = gnt_id ? bus.b_wdata : bus.a_wdata;
      end
      ST_ACCESS: begin
        state_n = ST_RESP;
        a_ack_n = win == PORT_A;
        b_ack_n = win == PORT_B;
        a_rdata_n = bus.mem_rd && win == PORT_A ? bus.mem_dout : bus.a_rdata;
        b_rdata_n = bus.mem_rd && win == PORT_B ? bus.mem_dout : bus.b_rdata;
      end
      ST_RESP: begin
        state_n = ST_IDLE;
        last_n = win;
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = state_n != ST_IDLE;
  end
  always_ff @(posedge clok) begin
    if (rst) begin
      state <= ST_IDLE;
      win <= PORT_A;
      last_gnt <= PORT_B;
      bus.mem_wri <= 1'b0;
      bus.mem_rd <= 1'b0;
      bus.mem_add <= '0;
      bus.mem_din <= '0;
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      win <= win_n;
      last_gnt <= last_n;
      bus.mem_wri <= wri_n;
      bus.mem_rd <= rd_n;
      bus.mem_add <= add_n;
      bus.mem_din <= din_n;
      bus.a_ack <= a_ack_n;
      bus.b_ack <= b_ack_n;
      bus.a_rdata <= a_rdata_n;
      bus.b_rdata <= b_rdata_n;
      bus.busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: directed checks of the round-robin SRAM arbiter against an 8x8 SRAM model
module tb_sram_rr_arbiter;
  logic clok, rst;
  int pass_cnt, total_cnt, wcnt, both_bad;
  logic [7:0] mem [8];
  sram_rr_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();
  sram_rr_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (.clok(clok), .rst(rst), .bus(bus));
  initial clok = 1'b0;
  always #5 clok = ~clok;
  always @(posedge clok) if (bus.mem_wri) mem[bus.mem_add] <= bus.mem_din;
  assign bus.mem_dout = bus.mem_rd ? mem[bus.mem_add] : 8'hzz;
  always @(posedge clok) if (bus.mem_wri) wcnt++;
  always @(negedge clok) if (bus.mem_wri && bus.mem_rd) both_bad++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else pass_cnt++;
  endtask
  task automatic tick;
    @(posedge clok);
    #1;
  endtask
  task automatic do_op(input logic p, input logic we, input logic [2:0] ad, input logic [7:0] wd, input logic [7:0] exp, input bit perturb);
    if (p) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd;
    end
    tick;
    chk("acc_busy", bus.busy, 1);
    chk("acc_wri", bus.mem_wri, we);
    chk("acc_rd", bus.mem_rd, !we);
    chk("acc_add", bus.mem_add, ad);
    if (we) chk("acc_din", bus.mem_din, wd);
    if (perturb) begin
      bus.a_addr = 3'd1; bus.a_wdata = 8'hEE;
    end
    tick;
    chk("resp_ack", p ? bus.b_ack : bus.a_ack, 1);
    chk("resp_other_ack", p ? bus.a_ack : bus.b_ack, 0);
    chk("resp_strobe", bus.mem_wri | bus.mem_rd, 0);
    if (!we) chk("resp_rdata", p ? bus.b_rdata : bus.a_rdata, exp);
    if (p) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    tick;
    chk("idle_busy", bus.busy, 0);
    chk("ack_pulse", bus.a_ack | bus.b_ack, 0);
  endtask
  initial begin
    int w0, na, nb;
    pass_cnt = 0; total_cnt = 0; wcnt = 0; both_bad = 0;
    rst = 1'b1;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    tick;
    chk("rst_strobe1", bus.mem_wri | bus.mem_rd, 0);
    tick;
    chk("rst_strobe2", bus.mem_wri | bus.mem_rd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_add", bus.mem_add, 0);
    chk("rst_din", bus.mem_din, 0);
    chk("rst_acks", {bus.a_ack, bus.b_ack}, 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    rst = 1'b0;
    tick;
    w0 = wcnt;
    do_op(0, 1, 3'd3, 8'hA5, 8'h00, 0);
    chk("single_wri_cycles", wcnt - w0, 1);
    do_op(0, 0, 3'd3, 8'h00, 8'hA5, 0);
    do_op(1, 1, 3'd7, 8'hFF, 8'h00, 0);
    do_op(1, 1, 3'd0, 8'h00, 8'h00, 0);
    do_op(1, 0, 3'd7, 8'h00, 8'hFF, 0);
    na = 0; nb = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 3'd3;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 3'd0; bus.b_wdata = 8'h10;
    for (int g = 0; g < 8; g++) begin
      tick;
      if (g % 2 == 0) begin
        chk("cont_a_rd", bus.mem_rd, 1);
        chk("cont_a_add", bus.mem_add, 3);
      end else begin
        chk("cont_b_wri", bus.mem_wri, 1);
        chk("cont_b_add", bus.mem_add, nb);
        chk("cont_b_din", bus.mem_din, 8'h10 + nb);
      end
      tick;
      chk("cont_ack_a", bus.a_ack, g % 2 == 0);
      chk("cont_ack_b", bus.b_ack, g % 2 == 1);
      if (g % 2 == 0) begin
        chk("cont_a_rdata", bus.a_rdata, 8'hA5);
        na++;
        if (na == 4) bus.a_req = 0;
      end else begin
        nb++;
        if (nb == 4) bus.b_req = 0;
        else begin
          bus.b_addr = nb[2:0]; bus.b_wdata = 8'h10 + nb[7:0];
        end
      end
      tick;
      chk("cont_idle", bus.busy, 0);
    end
    do_op(1, 0, 3'd2, 8'h00, 8'h12, 0);
    do_op(0, 1, 3'd6, 8'h5A, 8'h00, 1);
    do_op(0, 0, 3'd6, 8'h00, 8'h5A, 0);
    do_op(0, 0, 3'd1, 8'h00, 8'h11, 0);
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 3'd5; bus.a_wdata = 8'h3C;
    tick;
    chk("midrst_wri", bus.mem_wri, 1);
    rst = 1'b1; bus.a_req = 0;
    tick;
    chk("midrst_ack", bus.a_ack, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_wri_off", bus.mem_wri, 0);
    rst = 1'b0;
    tick;
    chk("midrst_no_late_ack", bus.a_ack, 0);
    do_op(0, 0, 3'd5, 8'h00, 8'h3C, 0);
    chk("no_wri_rd_overlap", both_bad, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
